// File: rtl/rand_seq_controller.sv
// Sequencer for the random-order sequence counter: programmable
// next-state table, seed load, free-run / single-step advance.
module rand_seq_controller #(
  parameter int W     = 3,
  parameter int DEPTH = 2**W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic [W-1:0] seed,
  input  logic         mode,
  input  logic         start,
  input  logic         stop,
  input  logic         step,
  output logic [W-1:0] qout,
  output logic         valid,
  output logic         busy,
  output logic         wrap,
  output logic         cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  state_t       st;
  logic [W-1:0] seed_reg;
  logic [W-1:0] tbl [DEPTH];
  logic [W-1:0] nxt;
  logic         nxt_wrap;

  // successor of the current value and whether it closes the loop
  always_comb begin
    nxt      = tbl[qout];
    nxt_wrap = (nxt == seed_reg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      qout     <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      wrap     <= 1'b0;
      cfg_err  <= 1'b0;
      seed_reg <= '0;
      for (int i = 0; i < DEPTH; i++)
        tbl[i] <= W'(i + 1);
    end else begin
      wrap    <= 1'b0;
      cfg_err <= 1'b0;
      case (st)
        IDLE: begin
          if (cfg_we)
            tbl[cfg_addr] <= cfg_data;
          if (start && !stop) begin
            seed_reg <= seed;
            qout     <= seed;
            valid    <= 1'b1;
            busy     <= 1'b1;
            st       <= mode ? PAUSE : RUN;
          end
        end
        RUN: begin
          cfg_err <= cfg_we;
          if (stop) begin
            st    <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else begin
            qout <= nxt;
            wrap <= nxt_wrap;
          end
        end
        PAUSE: begin
          cfg_err <= cfg_we;
          if (stop) begin
            st    <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (start) begin
            // resume: first free-run advance happens next edge
            st <= RUN;
          end else if (step) begin
            qout <= nxt;
            wrap <= nxt_wrap;
          end
        end
        default: begin
          st    <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rand_seq_controller.sv
// Bench for rand_seq_controller: directed scenarios plus random
// commands, all checked against a table-walk reference model.
module tb_rand_seq_controller;

  localparam int W = 3;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_we = 1'b0;
  logic [W-1:0] cfg_addr = '0;
  logic [W-1:0] cfg_data = '0;
  logic [W-1:0] seed = '0;
  logic         mode = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         step = 1'b0;
  logic [W-1:0] qout;
  logic         valid;
  logic         busy;
  logic         wrap;
  logic         cfg_err;

  int total = 0;
  int bad   = 0;

  // reference model: live flag, free-running flag, table as array
  int mt [D];
  int m_q, m_seed;
  bit m_live, m_free, m_wrap, m_err;

  rand_seq_controller #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .seed(seed), .mode(mode),
    .start(start), .stop(stop), .step(step),
    .qout(qout), .valid(valid), .busy(busy),
    .wrap(wrap), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < D; i++) mt[i] = (i + 1) % D;
    m_q = 0; m_seed = 0;
    m_live = 0; m_free = 0; m_wrap = 0; m_err = 0;
  endtask

  task automatic m_adv();
    m_q = mt[m_q];
    m_wrap = (m_q == m_seed);
  endtask

  task automatic m_edge();
    m_wrap = 0;
    m_err  = 0;
    if (!m_live) begin
      if (cfg_we) mt[cfg_addr] = cfg_data;
      if (start && !stop) begin
        m_seed = seed; m_q = seed;
        m_live = 1; m_free = !mode;
      end
    end else begin
      m_err = cfg_we;
      if (stop) m_live = 0;
      else if (m_free) m_adv();
      else if (start) m_free = 1;
      else if (step) m_adv();
    end
  endtask

  task automatic m_check();
    check("qout", qout, m_q);
    check("valid", valid, m_live);
    check("busy", busy, m_live);
    check("wrap", wrap, m_wrap);
    check("cfg_err", cfg_err, m_err);
  endtask

  task automatic cyc(input bit we, input int a, input int d,
                     input int sd, input bit md,
                     input bit sa, input bit so, input bit se);
    cfg_we = we; cfg_addr = W'(a); cfg_data = W'(d);
    seed = W'(sd); mode = md;
    start = sa; stop = so; step = se;
    @(posedge clk);
    m_edge();
    @(negedge clk);
    m_check();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int perm [D];
  int seq0 [9];
  int budget;

  initial begin
    perm = '{5, 6, 7, 4, 0, 2, 3, 1};
    seq0 = '{0, 5, 2, 7, 1, 6, 3, 4, 0};
    m_reset();
    @(negedge clk);
    check("rst_qout", qout, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_wrap", wrap, 0);
    check("rst_err", cfg_err, 0);
    rst = 1'b0;
    idle();

    // default table free-run from 0
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    check("def_load", qout, 0);
    check("def_load_wrap", wrap, 0);
    for (int k = 1; k <= 8; k++) begin
      idle();
      check("def_seq", qout, k % D);
      check("def_wrap", wrap, k == 8);
    end
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    idle();

    // program permutation table
    for (int i = 0; i < D; i++) cyc(1, i, perm[i], 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      idle();
      check("perm_seq", qout, seq0[k]);
      check("perm_wrap", wrap, k == 8);
    end
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    repeat (3) idle();
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    check("stop_q", qout, 7);
    check("stop_valid", valid, 0);
    check("stop_busy", busy, 0);
    idle();
    check("stop_hold", qout, 7);

    // single-step from seed 2, then resume; stop+start same cycle
    cyc(0, 0, 0, 2, 1, 1, 0, 0);
    idle(); idle();
    check("ss_hold", qout, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 1); check("ss1", qout, 7);
    cyc(0, 0, 0, 0, 0, 0, 0, 1); check("ss2", qout, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1); check("ss3", qout, 6);
    cyc(0, 0, 0, 0, 0, 1, 0, 1); check("resume_edge", qout, 6);
    idle(); check("fr3", qout, 3);
    idle(); check("fr4", qout, 4);
    idle(); check("fr0", qout, 0);
    idle(); check("fr5", qout, 5);
    idle(); check("fr2", qout, 2); check("fr_wrap", wrap, 1);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    check("stopwin_busy", busy, 0);
    cyc(0, 0, 0, 1, 0, 1, 1, 0);
    check("stopwin_idle", busy, 0);

    // config write while running is dropped
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    cyc(1, 0, 3, 0, 0, 0, 0, 0);
    check("err_pulse", cfg_err, 1);
    idle();
    check("err_once", cfg_err, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    check("readback", qout, 5);

    // async reset mid-run at 6
    budget = 20;
    while (m_q != 6 && budget > 0) begin idle(); budget--; end
    check("reach6", qout, 6);
    #2 rst = 1'b1;
    #1;
    m_reset();
    check("arst_q", qout, 0);
    check("arst_valid", valid, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    idle(); check("rst_tbl1", qout, 1);
    idle(); check("rst_tbl2", qout, 2);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);

    // self-loop with new entry written on start edge
    cyc(1, 4, 4, 4, 0, 1, 0, 0);
    check("loop_load_wrap", wrap, 0);
    repeat (4) begin
      idle();
      check("loop_q", qout, 4);
      check("loop_wrap", wrap, 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 1, 0);

    // random command mix
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, D - 1),
          $urandom_range(0, D - 1), $urandom_range(0, D - 1),
          $urandom_range(0, 1),
          $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
